// File: rtl/ctrl_sequencer_pkg.sv
// Shared constants for the control sequencer: control-bus bit positions,
// opcode classes and FSM state encodings.
package ctrl_sequencer_pkg;

    localparam int SIGNALS_SIZE_C = 5;
    localparam int OPCODE_W       = 5;

    localparam int SIG_PC_INC        = 0;
    localparam int SIG_MAR_W_EN      = 1;
    localparam int SIG_REG_RW        = 2;
    localparam int SIG_REG_SELECT_IN = 3;
    localparam int SIG_FLAGS_W_EN    = 4;

    localparam logic [1:0]          OP_ALU_CLASS = 2'b00;
    localparam logic [OPCODE_W-1:0] OP_MOVI      = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_CMP       = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_NOP       = 5'b11110;
    localparam logic [OPCODE_W-1:0] OP_HALT      = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALTED = 3'd5
    } seq_state_t;

    function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
        return op[OPCODE_W-1:OPCODE_W-2] == OP_ALU_CLASS;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control/status bundle between the host controller (master) and the
// instruction sequencer (slave).
interface ctrl_sequencer_if #(
    parameter int SIGNALS_SIZE = 5,
    parameter int CNT_W        = 16
);
    logic                    run;
    logic                    step;
    logic                    code_w_en;
    logic [4:0]              opcode;
    logic [SIGNALS_SIZE-1:0] signals;
    logic                    pc_clr;
    logic                    busy;
    logic                    halted;
    logic                    illegal;
    logic [CNT_W-1:0]        instr_count;

    modport master (
        output run, step, code_w_en, opcode,
        input  signals, pc_clr, busy, halted, illegal, instr_count
    );

    modport slave (
        input  run, step, code_w_en, opcode,
        output signals, pc_clr, busy, halted, illegal, instr_count
    );
endinterface

// File: rtl/ctrl_sequencer_exec_decode.sv
// Combinational decode of the latched opcode into EXEC-cycle strobes
// plus halt/illegal classification.
module seq_exec_decode
    import ctrl_sequencer_pkg::*;
(
    input  logic [OPCODE_W-1:0] op,
    output logic                reg_rw,
    output logic                reg_select_in,
    output logic                flags_w_en,
    output logic                is_halt,
    output logic                is_illegal
);

    always_comb begin
        reg_rw        = 1'b0;
        reg_select_in = 1'b0;
        flags_w_en    = 1'b0;
        is_halt       = 1'b0;
        is_illegal    = 1'b0;
        if (is_alu_op(op)) begin
            reg_rw     = 1'b1;
            flags_w_en = 1'b1;
        end else begin
            case (op)
                OP_MOVI: begin
                    reg_rw        = 1'b1;
                    reg_select_in = 1'b1;
                end
                OP_CMP:  flags_w_en = 1'b1;
                OP_NOP:  ;
                OP_HALT: is_halt = 1'b1;
                default: is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/wait/decode/execute sequencer driving the datapath control bus.
// Optional single-step start is enabled by defining SEQ_STEP_EN.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int SIGNALS_SIZE = SIGNALS_SIZE_C,
    parameter int WAIT_CYCLES  = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_sequencer_if.slave   bus
);

    localparam logic [2:0]       WAIT_LOAD = 3'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t              state;
    seq_state_t              state_next;
    logic [2:0]              wait_cnt;
    logic [OPCODE_W-1:0]     op_q;
    logic                    code_w_en_q;
    logic                    code_w_rise;
    logic                    start_req;
    logic                    pc_clr_q;
    logic                    illegal_q;
    logic [CNT_W-1:0]        instr_count_q;
    logic [SIGNALS_SIZE-1:0] sig;

    logic dec_reg_rw;
    logic dec_reg_select_in;
    logic dec_flags_w_en;
    logic dec_is_halt;
    logic dec_is_illegal;

    seq_exec_decode u_exec_decode (
        .op            (op_q),
        .reg_rw        (dec_reg_rw),
        .reg_select_in (dec_reg_select_in),
        .flags_w_en    (dec_flags_w_en),
        .is_halt       (dec_is_halt),
        .is_illegal    (dec_is_illegal)
    );

    assign code_w_rise = bus.code_w_en & ~code_w_en_q;

`ifdef SEQ_STEP_EN
    // A step pulse only matters in IDLE; once running, EXEC consults run alone,
    // so a step-started instruction always returns to IDLE afterwards.
    assign start_req = (bus.run | bus.step) & ~bus.code_w_en;
`else
    logic step_unused;
    assign step_unused = bus.step;
    assign start_req   = bus.run & ~bus.code_w_en;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start_req) state_next = ST_FETCH;
            ST_FETCH:  state_next = bus.code_w_en ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (bus.code_w_en)      state_next = ST_IDLE;
                else if (wait_cnt == 3'd0) state_next = ST_DECODE;
            end
            ST_DECODE: state_next = bus.code_w_en ? ST_IDLE : ST_EXEC;
            ST_EXEC: begin
                if (bus.code_w_en)   state_next = ST_IDLE;
                else if (dec_is_halt) state_next = ST_HALTED;
                else if (bus.run)    state_next = ST_FETCH;
                else                 state_next = ST_IDLE;
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_IDLE;
        endcase
        // A fresh code load always restarts from IDLE, whatever was in flight.
        if (code_w_rise) state_next = ST_IDLE;
    end

    always_comb begin
        sig = '0;
        case (state)
            ST_FETCH: begin
                sig[SIG_PC_INC]   = 1'b1;
                sig[SIG_MAR_W_EN] = 1'b1;
            end
            ST_EXEC: begin
                sig[SIG_REG_RW]        = dec_reg_rw;
                sig[SIG_REG_SELECT_IN] = dec_reg_select_in;
                sig[SIG_FLAGS_W_EN]    = dec_flags_w_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= 3'd0;
            op_q          <= '0;
            code_w_en_q   <= 1'b0;
            pc_clr_q      <= 1'b0;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state       <= state_next;
            code_w_en_q <= bus.code_w_en;
            pc_clr_q    <= code_w_rise;
            if (state == ST_FETCH)
                wait_cnt <= WAIT_LOAD;
            else if (state == ST_WAIT && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
            if (state == ST_DECODE)
                op_q <= bus.opcode;
            // EXEC is committed once entered, even if a code load arrives now.
            if (state == ST_EXEC) begin
                if (instr_count_q != '1)
                    instr_count_q <= instr_count_q + CNT_ONE;
                if (dec_is_illegal)
                    illegal_q <= 1'b1;
            end
        end
    end

    assign bus.signals     = sig;
    assign bus.pc_clr      = pc_clr_q;
    assign bus.busy        = (state != ST_IDLE) && (state != ST_HALTED);
    assign bus.halted      = (state == ST_HALTED);
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed scoreboard bench for ctrl_sequencer; step checks follow SEQ_STEP_EN.
module tb_ctrl_sequencer;

    localparam int TB_WAIT = 1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    ctrl_sequencer_if #(.SIGNALS_SIZE(5), .CNT_W(16)) bus ();
    ctrl_sequencer_if #(.SIGNALS_SIZE(5), .CNT_W(4))  bus2 ();

    ctrl_sequencer #(.SIGNALS_SIZE(5), .WAIT_CYCLES(TB_WAIT), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ctrl_sequencer #(.SIGNALS_SIZE(5), .WAIT_CYCLES(2), .CNT_W(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Reference EXEC strobes: {flags_w_en, reg_select_in, reg_rw, mar_w_en, pc_inc}
    function automatic logic [4:0] exec_sig(input logic [4:0] op);
        casez (op)
            5'b00???: return 5'b10100;
            5'b01000: return 5'b01100;
            5'b01001: return 5'b10000;
            default:  return 5'b00000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op);
        bus.opcode = op;
        bus.run    = 1'b1;
        exp_q.push_back(5'b00011);
        for (int i = 0; i < TB_WAIT + 1; i++) exp_q.push_back(5'b00000);
        exp_q.push_back(exec_sig(op));
    endtask

    task automatic checkScoreboard(input string tag);
        logic [4:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, observed=%0h", tag, bus.signals);
        end else begin
            exp = exp_q.pop_front();
            checkOutput(tag, 32'(bus.signals), 32'(exp));
            checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        end
    endtask

    task automatic runInstr(input logic [4:0] op, input bit last);
        applyStimulus(op);
        repeat (3 + TB_WAIT) begin
            @(negedge clk);
            checkScoreboard("sig");
        end
        if (last) bus.run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.run = 1'b0;  bus.step = 1'b0;  bus.code_w_en = 1'b0;  bus.opcode = 5'b0;
        bus2.run = 1'b0; bus2.step = 1'b0; bus2.code_w_en = 1'b0; bus2.opcode = 5'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_signals", 32'(bus.signals), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_halted", 32'(bus.halted), 32'd0);
        checkOutput("rst_illegal", 32'(bus.illegal), 32'd0);
        checkOutput("rst_count", 32'(bus.instr_count), 32'd0);
        checkOutput("rst_pc_clr", 32'(bus.pc_clr), 32'd0);
        rst = 1'b0;

        // MOVI alone
        runInstr(5'b01000, 1'b1);
        @(negedge clk);
        checkOutput("movi_count", 32'(bus.instr_count), 32'd1);
        checkOutput("movi_idle", 32'(bus.busy), 32'd0);

        // ALU then CMP back to back
        runInstr(5'b00010, 1'b0);
        runInstr(5'b01001, 1'b1);
        @(negedge clk);
        checkOutput("alucmp_count", 32'(bus.instr_count), 32'd3);

        // HALT with run held high
        runInstr(5'b11111, 1'b0);
        @(negedge clk);
        checkOutput("halt_halted", 32'(bus.halted), 32'd1);
        checkOutput("halt_busy", 32'(bus.busy), 32'd0);
        checkOutput("halt_count", 32'(bus.instr_count), 32'd4);
        repeat (3) begin
            @(negedge clk);
            checkOutput("halt_signals", 32'(bus.signals), 32'd0);
            checkOutput("halt_stays", 32'(bus.halted), 32'd1);
        end
        bus.code_w_en = 1'b1;
        bus.run = 1'b0;
        @(negedge clk);
        checkOutput("reload_pc_clr", 32'(bus.pc_clr), 32'd1);
        checkOutput("reload_halted", 32'(bus.halted), 32'd0);
        checkOutput("reload_busy", 32'(bus.busy), 32'd0);
        bus.code_w_en = 1'b0;
        @(negedge clk);
        checkOutput("reload_pc_clr_pulse", 32'(bus.pc_clr), 32'd0);
        checkOutput("reload_count", 32'(bus.instr_count), 32'd4);

        // Illegal opcode is sticky across later valid ops
        runInstr(5'b10101, 1'b1);
        @(negedge clk);
        checkOutput("illegal_set", 32'(bus.illegal), 32'd1);
        checkOutput("illegal_count", 32'(bus.instr_count), 32'd5);
        runInstr(5'b01000, 1'b1);
        @(negedge clk);
        checkOutput("illegal_sticky", 32'(bus.illegal), 32'd1);
        checkOutput("after_illegal_count", 32'(bus.instr_count), 32'd6);

        // Code load during WAIT aborts the instruction
        bus.opcode = 5'b00010;
        bus.run = 1'b1;
        @(negedge clk);
        checkOutput("abort_fetch", 32'(bus.signals), 32'b00011);
        @(negedge clk);
        checkOutput("abort_wait_busy", 32'(bus.busy), 32'd1);
        bus.code_w_en = 1'b1;
        bus.run = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle", 32'(bus.busy), 32'd0);
        checkOutput("abort_pc_clr", 32'(bus.pc_clr), 32'd1);
        bus.code_w_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_strobe", 32'(bus.signals), 32'd0);
            checkOutput("abort_count", 32'(bus.instr_count), 32'd6);
        end

        // Single-step pulse
        bus.opcode = 5'b01001;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
`ifdef SEQ_STEP_EN
        checkOutput("step_fetch", 32'(bus.signals), 32'b00011);
        repeat (TB_WAIT + 1) begin
            @(negedge clk);
            checkOutput("step_mid", 32'(bus.signals), 32'd0);
        end
        @(negedge clk);
        checkOutput("step_exec", 32'(bus.signals), 32'b10000);
        repeat (3) begin
            @(negedge clk);
            checkOutput("step_idle", 32'(bus.busy), 32'd0);
            checkOutput("step_count", 32'(bus.instr_count), 32'd7);
        end
`else
        repeat (4) begin
            checkOutput("step_ignored", 32'(bus.busy), 32'd0);
            checkOutput("step_count", 32'(bus.instr_count), 32'd6);
            @(negedge clk);
        end
`endif

        // Asynchronous reset in the middle of WAIT
        bus.opcode = 5'b01000;
        bus.run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstmid_busy_before", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstmid_busy", 32'(bus.busy), 32'd0);
        checkOutput("rstmid_signals", 32'(bus.signals), 32'd0);
        checkOutput("rstmid_count", 32'(bus.instr_count), 32'd0);
        checkOutput("rstmid_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.run = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_after", 32'(bus.busy), 32'd0);

        // 4-bit counter saturation with WAIT_CYCLES=2
        bus2.opcode = 5'b11110;
        bus2.run = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("sat_first_exec_count", 32'(bus2.instr_count), 32'd0);
        @(negedge clk);
        checkOutput("sat_first_retired", 32'(bus2.instr_count), 32'd1);
        checkOutput("sat_second_fetch", 32'(bus2.signals), 32'b00011);
        repeat (95) @(negedge clk);
        checkOutput("sat_count", 32'(bus2.instr_count), 32'd15);
        bus2.run = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("sat_hold", 32'(bus2.instr_count), 32'd15);
        checkOutput("sat_idle", 32'(bus2.busy), 32'd0);
        checkOutput("sat_illegal", 32'(bus2.illegal), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
